// File: rtl/enoc_node_interface.sv
// rtl/enoc_node_interface.sv - network node interface with independent TX/RX packet queues and delivery counters

module enoc_node_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_push_val,
    output logic             o_push_rdy,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_pop_val,
    input  logic             i_pop_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             push, pop;

    // Ready and valid come from occupancy alone, so a same-cycle pop never opens a slot.
    assign o_push_rdy = (occ_q < DEPTH_C);
    assign o_pop_val  = (occ_q != '0);
    assign o_pop_data = mem_q[rd_ptr_q];
    assign push       = i_push_val & o_push_rdy;
    assign pop        = o_pop_val & i_pop_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + CW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is left unreset; entries are only observable once written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module enoc_node_interface #(
    parameter int PACKET_WIDTH = 32,
    parameter int TX_DEPTH     = 4,
    parameter int RX_DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PACKET_WIDTH-1:0] i_tx_pkt,
    input  logic                    i_tx_val,
    output logic                    o_tx_rdy,
    output logic [PACKET_WIDTH-1:0] o_net_data,
    output logic                    o_net_data_val,
    input  logic                    i_net_en,
    input  logic [PACKET_WIDTH-1:0] i_net_data,
    input  logic                    i_net_data_val,
    output logic                    o_net_en,
    output logic [PACKET_WIDTH-1:0] o_rx_pkt,
    output logic                    o_rx_val,
    input  logic                    i_rx_rdy,
    output logic [31:0]             o_tx_count,
    output logic [31:0]             o_rx_count
);
    logic [31:0] tx_count_q, tx_count_d;
    logic [31:0] rx_count_q, rx_count_d;

    enoc_node_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push_data (i_tx_pkt),
        .i_push_val  (i_tx_val),
        .o_push_rdy  (o_tx_rdy),
        .o_pop_data  (o_net_data),
        .o_pop_val   (o_net_data_val),
        .i_pop_rdy   (i_net_en)
    );

    enoc_node_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push_data (i_net_data),
        .i_push_val  (i_net_data_val),
        .o_push_rdy  (o_net_en),
        .o_pop_data  (o_rx_pkt),
        .o_pop_val   (o_rx_val),
        .i_pop_rdy   (i_rx_rdy)
    );

    always_comb begin
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        if (o_net_data_val && i_net_en) begin
            tx_count_d = tx_count_q + 32'd1;
        end
        if (i_net_data_val && o_net_en) begin
            rx_count_d = rx_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
        end
    end

    assign o_tx_count = tx_count_q;
    assign o_rx_count = rx_count_q;
endmodule
